// File: rtl/rr_arbiter_pkg.sv
// Shared definitions for the round-robin arbiter: FSM state encoding and
// default sizing constants.
package rr_arbiter_pkg;

   localparam int RR_N_DEFAULT        = 4;
   localparam int RR_HOLD_MAX_DEFAULT = 8;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      GRANT   = 2'd1,
      RELEASE = 2'd2
   } rr_state_t;

endpackage

// File: rtl/rr_pick.sv
// Rotating-priority search. Returns the first set request bit found when
// scanning upward from ptr, wrapping from N-1 back to 0.
//   req   : request vector
//   ptr   : index with highest priority this cycle (always < N)
//   valid : at least one request bit is set
//   idx   : index of the winning requester (0 when valid is low)
module rr_pick
   import rr_arbiter_pkg::*;
#(
   parameter int N    = RR_N_DEFAULT,
   parameter int ID_W = $clog2(N)
) (
   input  logic [N-1:0]    req,
   input  logic [ID_W-1:0] ptr,
   output logic            valid,
   output logic [ID_W-1:0] idx
);

   int c;

   // Scan from the farthest offset down to offset 0 so that the closest
   // requester to ptr is the last (and therefore final) assignment.
   always_comb begin
      valid = 1'b0;
      idx   = '0;
      c     = 0;
      for (int i = N - 1; i >= 0; i--) begin
         c = int'(ptr) + i;
         if (c >= N) begin
            c = c - N;
         end
         if (req[c[ID_W-1:0]]) begin
            valid = 1'b1;
            idx   = c[ID_W-1:0];
         end
      end
   end

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter with a per-owner hold limit. The owner keeps the grant
// until it drops its request or has held it for HOLD_MAX cycles, then one
// gap cycle follows before the next winner is granted.
//   clk     : clock, all state changes on the rising edge
//   resetn  : asynchronous active-low reset
//   en      : arbitration enable, blocks new grants only
//   req     : request vector, bit i = requester i
//   gnt     : registered one-hot grant, zero when nobody owns the resource
//   gnt_id  : index of the current owner, zero when gnt is zero
//   busy    : high whenever gnt is non-zero
//   expired : one-cycle pulse in the gap cycle after a hold-limit revoke
//
// state   | meaning
// IDLE    | no owner; arbitrate when en is high
// GRANT   | owner holds the grant; hold_cnt counts its cycles
// RELEASE | one-cycle gap with gnt=0; ptr already points past last owner
module rr_arbiter
   import rr_arbiter_pkg::*;
#(
   parameter int N        = RR_N_DEFAULT,
   parameter int HOLD_MAX = RR_HOLD_MAX_DEFAULT
) (
   input  logic                 clk,
   input  logic                 resetn,
   input  logic                 en,
   input  logic [N-1:0]         req,
   output logic [N-1:0]         gnt,
   output logic [$clog2(N)-1:0] gnt_id,
   output logic                 busy,
   output logic                 expired
);

   localparam int ID_W = $clog2(N);
   localparam int HC_W = $clog2(HOLD_MAX + 1);
   localparam logic [N-1:0] GNT_ONE = {{(N-1){1'b0}}, 1'b1};

   rr_state_t         state_q, state_d;
   logic [ID_W-1:0]   owner_q, owner_d;
   logic [ID_W-1:0]   ptr_q, ptr_d;
   logic [HC_W-1:0]   hold_q, hold_d;
   logic [N-1:0]      gnt_q, gnt_d;
   logic              busy_q, busy_d;
   logic              expired_q, expired_d;
   logic [ID_W-1:0]   ptr_after_owner;

   logic              pick_valid;
   logic [ID_W-1:0]   pick_idx;

   rr_pick #(
      .N    (N),
      .ID_W (ID_W)
   ) u_pick (
      .req   (req),
      .ptr   (ptr_q),
      .valid (pick_valid),
      .idx   (pick_idx)
   );

   assign ptr_after_owner = (owner_q == ID_W'(N - 1)) ? '0 : owner_q + ID_W'(1);

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q   <= IDLE;
         owner_q   <= '0;
         ptr_q     <= '0;
         hold_q    <= '0;
         gnt_q     <= '0;
         busy_q    <= 1'b0;
         expired_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         owner_q   <= owner_d;
         ptr_q     <= ptr_d;
         hold_q    <= hold_d;
         gnt_q     <= gnt_d;
         busy_q    <= busy_d;
         expired_q <= expired_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      owner_d   = owner_q;
      ptr_d     = ptr_q;
      hold_d    = hold_q;
      expired_d = 1'b0;

      case (state_q)
         IDLE, RELEASE: begin
            if (en && pick_valid) begin
               state_d = GRANT;
               owner_d = pick_idx;
               hold_d  = HC_W'(1);
            end else begin
               state_d = IDLE;
               owner_d = '0;
               hold_d  = '0;
            end
         end
         GRANT: begin
            // A dropped request takes precedence over the hold limit, so a
            // coincident drop never reports an expiry.
            if (!req[owner_q]) begin
               state_d = RELEASE;
               ptr_d   = ptr_after_owner;
               owner_d = '0;
               hold_d  = '0;
            end else if (hold_q == HC_W'(HOLD_MAX)) begin
               state_d   = RELEASE;
               ptr_d     = ptr_after_owner;
               owner_d   = '0;
               hold_d    = '0;
               expired_d = 1'b1;
            end else begin
               hold_d = hold_q + HC_W'(1);
            end
         end
         default: begin
            state_d = IDLE;
            owner_d = '0;
            hold_d  = '0;
         end
      endcase

      busy_d = (state_d == GRANT);
      gnt_d  = busy_d ? (GNT_ONE << owner_d) : '0;
   end

   assign gnt     = gnt_q;
   assign gnt_id  = owner_q;
   assign busy    = busy_q;
   assign expired = expired_q;

endmodule

// File: tb/tb_rr_arbiter.sv
// Self-checking bench for rr_arbiter (N=4, HOLD_MAX=8): directed scenarios
// followed by randomized traffic, all compared against a cycle model that
// tracks the owner, its held-cycle count and the rotating pointer.
module tb_rr_arbiter;

   localparam int N    = 4;
   localparam int HOLD = 8;

   logic          clk    = 1'b0;
   logic          resetn = 1'b0;
   logic          en     = 1'b0;
   logic [N-1:0]  req    = '0;
   logic [N-1:0]  gnt;
   logic [1:0]    gnt_id;
   logic          busy;
   logic          expired;

   int n_cmp = 0;
   int n_bad = 0;

   // reference model
   int m_owner = -1;
   int m_held  = 0;
   int m_ptr   = 0;
   bit m_exp   = 1'b0;

   always #5 clk = ~clk;

   rr_arbiter #(.N(N), .HOLD_MAX(HOLD)) dut (
      .clk     (clk),
      .resetn  (resetn),
      .en      (en),
      .req     (req),
      .gnt     (gnt),
      .gnt_id  (gnt_id),
      .busy    (busy),
      .expired (expired)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic bit req_bit(input logic [N-1:0] r, input int i);
      logic [N-1:0] sh;
      sh = r >> i;
      return sh[0];
   endfunction

   function automatic int pick_ref(input logic [N-1:0] r, input int p);
      for (int k = 0; k < N; k++) begin
         if (req_bit(r, (p + k) % N)) return (p + k) % N;
      end
      return -1;
   endfunction

   task automatic model_reset();
      m_owner = -1;
      m_held  = 0;
      m_ptr   = 0;
      m_exp   = 1'b0;
   endtask

   task automatic model_edge();
      int w;
      m_exp = 1'b0;
      if (m_owner >= 0) begin
         if (!req_bit(req, m_owner)) begin
            m_ptr   = (m_owner + 1) % N;
            m_owner = -1;
            m_held  = 0;
         end else if (m_held == HOLD) begin
            m_ptr   = (m_owner + 1) % N;
            m_owner = -1;
            m_held  = 0;
            m_exp   = 1'b1;
         end else begin
            m_held++;
         end
      end else if (en) begin
         w = pick_ref(req, m_ptr);
         if (w >= 0) begin
            m_owner = w;
            m_held  = 1;
         end
      end
   endtask

   task automatic check_model(input string tag);
      logic [N-1:0] eg;
      eg = (m_owner >= 0) ? (4'b0001 << m_owner) : 4'b0000;
      chk({tag, ".gnt"}, 32'(gnt), 32'(eg));
      chk({tag, ".gnt_id"}, 32'(gnt_id), (m_owner >= 0) ? 32'(m_owner) : 32'd0);
      chk({tag, ".busy"}, 32'(busy), (m_owner >= 0) ? 32'd1 : 32'd0);
      chk({tag, ".expired"}, 32'(expired), 32'(m_exp));
   endtask

   task automatic step(input string tag);
      @(posedge clk);
      model_edge();
      @(negedge clk);
      check_model(tag);
   endtask

   task automatic do_reset(input string tag);
      @(negedge clk);
      resetn = 1'b0;
      #1;
      chk({tag, ".rst_gnt"}, 32'(gnt), 32'd0);
      chk({tag, ".rst_gnt_id"}, 32'(gnt_id), 32'd0);
      chk({tag, ".rst_busy"}, 32'(busy), 32'd0);
      chk({tag, ".rst_expired"}, 32'(expired), 32'd0);
      model_reset();
      @(negedge clk);
      resetn = 1'b1;
   endtask

   initial begin
      int order[$];
      int exp_order[5];
      bit prev_busy;
      int nexp;
      bit seen;

      exp_order = '{0, 1, 2, 3, 0};

      // power-on reset
      do_reset("por");

      // reset in the middle of a grant to requester 1
      en  = 1'b1;
      req = 4'b0010;
      step("rst_mid");
      step("rst_mid");
      chk("rst_mid.pre_gnt", 32'(gnt), 32'h2);
      do_reset("rst_mid");
      req = 4'b0001;
      step("rst_after");
      chk("rst_after.gnt", 32'(gnt), 32'h1);

      // rotation: each owner drops its request after two grant cycles
      do_reset("rot");
      en        = 1'b1;
      req       = 4'b1111;
      prev_busy = 1'b0;
      for (int i = 0; i < 20; i++) begin
         step("rot");
         if (gnt != 0 && !prev_busy) order.push_back(int'(gnt_id));
         prev_busy = (gnt != 0);
         req = 4'b1111;
         if (m_owner >= 0 && m_held == 2) req = 4'b1111 & ~(4'b0001 << m_owner);
      end
      chk("rot.count", 32'(order.size() >= 5), 32'd1);
      for (int i = 0; i < 5; i++) begin
         if (i < order.size()) chk("rot.order", 32'(order[i]), 32'(exp_order[i]));
      end

      // timeout: sole requester held for 30 cycles
      do_reset("tmo");
      en   = 1'b1;
      req  = 4'b0100;
      nexp = 0;
      for (int i = 0; i < 30; i++) begin
         step("tmo");
         if (expired) nexp++;
      end
      chk("tmo.expired_count", 32'(nexp), 32'd3);

      // pointer wrap: owner 3 expires while requester 0 also waits
      do_reset("wrap");
      en  = 1'b1;
      req = 4'b1000;
      step("wrap");
      req  = 4'b1001;
      seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
         step("wrap");
         if (expired) seen = 1'b1;
      end
      chk("wrap.expired_seen", 32'(seen), 32'd1);
      step("wrap");
      chk("wrap.gnt", 32'(gnt), 32'h1);
      chk("wrap.gnt_id", 32'(gnt_id), 32'd0);

      // enable gating
      do_reset("en");
      en  = 1'b0;
      req = 4'b0010;
      repeat (5) step("en_off");
      chk("en_off.gnt", 32'(gnt), 32'd0);
      en = 1'b1;
      step("en_on");
      en = 1'b0;
      repeat (4) step("en_drop");
      chk("en_drop.busy", 32'(busy), 32'd1);
      chk("en_drop.gnt", 32'(gnt), 32'h2);
      req = 4'b0000;
      step("en_rel");
      step("en_idle");
      chk("en_idle.gnt", 32'(gnt), 32'd0);

      // request drop coinciding with the hold limit
      do_reset("sim");
      en  = 1'b1;
      req = 4'b0001;
      repeat (HOLD) step("sim");
      req = 4'b0000;
      step("sim_drop");
      chk("sim_drop.expired", 32'(expired), 32'd0);
      chk("sim_drop.gnt", 32'(gnt), 32'd0);

      // randomized traffic
      do_reset("rnd");
      en = 1'b1;
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 3) == 0) req = 4'($urandom_range(0, 15));
         en = ($urandom_range(0, 7) != 0);
         if ($urandom_range(0, 99) == 0) do_reset("rnd");
         step("rnd");
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
